// File: rtl/led_decoder_seq_if.sv
// ---------------------------------------------------------------------------
// led_decoder_seq_if : control and LED bus between switch logic and LED bank
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface led_decoder_seq_if #(
  parameter int SEL_W = 2
);
  localparam int N = 2 ** SEL_W;

  logic             en;
  logic             mode;
  logic             dir;
  logic [SEL_W-1:0] a;
  logic [N-1:0]     led;
  logic [SEL_W-1:0] idx;
  logic             step;

  modport master (
    output en, mode, dir, a,
    input  led, idx, step
  );

  modport slave (
    input  en, mode, dir, a,
    output led, idx, step
  );
endinterface

`default_nettype wire

// File: rtl/led_decoder_seq.sv
// ---------------------------------------------------------------------------
// led_decoder_seq : registered one-hot LED driver with DECODE and SCAN modes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_decoder_seq #(
  parameter int SEL_W  = 2,
  parameter int DIV    = 4,
  parameter int BOUNCE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  led_decoder_seq_if.slave bus
);
  localparam int N     = 2 ** SEL_W;
  localparam int CNT_W = $clog2(DIV) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [SEL_W-1:0] IDX_ONE    = SEL_W'(1);
  localparam logic [SEL_W-1:0] IDX_MAX    = '1;
  localparam logic [SEL_W-1:0] IDX_MAX_M1 = IDX_MAX - IDX_ONE;
  localparam logic [N-1:0]     LED_ONE    = N'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [N-1:0]     led_q, led_d;
  logic [SEL_W-1:0] idx_q, idx_d, idx_nxt;
  logic             step_q, step_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             dir_q, dir_q_d, dir_nxt;

  generate
    if (BOUNCE != 0) begin : g_bounce
      // Direction is latched at entry and flips only when an end is reached.
      always_comb begin
        idx_nxt = idx_q;
        dir_nxt = dir_q;
        if (dir_q && (idx_q == IDX_MAX)) begin
          idx_nxt = IDX_MAX_M1;
          dir_nxt = 1'b0;
        end else if (!dir_q && (idx_q == '0)) begin
          idx_nxt = IDX_ONE;
          dir_nxt = 1'b1;
        end else begin
          idx_nxt = dir_q ? (idx_q + IDX_ONE) : (idx_q - IDX_ONE);
        end
      end
    end else begin : g_wrap
      always_comb begin
        idx_nxt = bus.dir ? (idx_q + IDX_ONE) : (idx_q - IDX_ONE);
        dir_nxt = dir_q;
      end
    end
  endgenerate

  always_comb begin
    state_d = IDLE;
    if (bus.en) begin
      state_d = bus.mode ? SCAN : DECODE;
    end
    led_d   = led_q;
    idx_d   = idx_q;
    step_d  = 1'b0;
    cnt_d   = '0;
    dir_q_d = dir_q;
    case (state_d)
      IDLE: begin
        led_d = '0;
      end
      DECODE: begin
        idx_d = bus.a;
        led_d = LED_ONE << bus.a;
      end
      SCAN: begin
        if (state != SCAN) begin
          idx_d   = bus.a;
          led_d   = LED_ONE << bus.a;
          dir_q_d = bus.dir;
        end else if (cnt == CNT_LAST) begin
          idx_d   = idx_nxt;
          led_d   = LED_ONE << idx_nxt;
          step_d  = 1'b1;
          dir_q_d = dir_nxt;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: begin
        led_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      led_q  <= '0;
      idx_q  <= '0;
      step_q <= 1'b0;
      cnt    <= '0;
      dir_q  <= 1'b1;
    end else begin
      state  <= state_d;
      led_q  <= led_d;
      idx_q  <= idx_d;
      step_q <= step_d;
      cnt    <= cnt_d;
      dir_q  <= dir_q_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.idx  = idx_q;
  assign bus.step = step_q;
endmodule

`default_nettype wire

// File: tb/tb_led_decoder_seq.sv
// ---------------------------------------------------------------------------
// tb_led_decoder_seq : directed and randomized checks over four configurations
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_led_decoder_seq;
  logic       clk = 1'b0;
  logic       rst_n, en, mode, dir;
  logic [1:0] a;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  // Configurations: 0 wrap DIV=4, 1 wrap DIV=1, 2 bounce DIV=1, 3 bounce SEL_W=1 DIV=1
  localparam int SW [4] = '{2, 2, 2, 1};
  localparam int DV [4] = '{4, 1, 1, 1};
  localparam int BN [4] = '{0, 0, 1, 1};

  led_decoder_seq_if #(.SEL_W(2)) if0 ();
  led_decoder_seq_if #(.SEL_W(2)) if1 ();
  led_decoder_seq_if #(.SEL_W(2)) if2 ();
  led_decoder_seq_if #(.SEL_W(1)) if3 ();

  assign if0.en = en;  assign if0.mode = mode;  assign if0.dir = dir;  assign if0.a = a;
  assign if1.en = en;  assign if1.mode = mode;  assign if1.dir = dir;  assign if1.a = a;
  assign if2.en = en;  assign if2.mode = mode;  assign if2.dir = dir;  assign if2.a = a;
  assign if3.en = en;  assign if3.mode = mode;  assign if3.dir = dir;  assign if3.a = a[0];

  led_decoder_seq #(.SEL_W(2), .DIV(4), .BOUNCE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  led_decoder_seq #(.SEL_W(2), .DIV(1), .BOUNCE(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  led_decoder_seq #(.SEL_W(2), .DIV(1), .BOUNCE(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  led_decoder_seq #(.SEL_W(1), .DIV(1), .BOUNCE(1)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  logic [3:0] led_o  [4];
  logic [1:0] idx_o  [4];
  logic       step_o [4];

  assign led_o[0] = if0.led;            assign idx_o[0] = if0.idx;          assign step_o[0] = if0.step;
  assign led_o[1] = if1.led;            assign idx_o[1] = if1.idx;          assign step_o[1] = if1.step;
  assign led_o[2] = if2.led;            assign idx_o[2] = if2.idx;          assign step_o[2] = if2.step;
  assign led_o[3] = {2'b00, if3.led};   assign idx_o[3] = {1'b0, if3.idx};  assign step_o[3] = if3.step;

  // Reference: activity kind (0 off, 1 decode, 2 scan), position, cycles since
  // entry/last step and a signed heading, all in plain integer arithmetic.
  int   m_st [4], m_pos [4], m_age [4], m_head [4];
  logic m_step [4];
  int   mn, mw;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      mn        = 1 << SW[k];
      m_step[k] = 1'b0;
      if (!rst_n) begin
        m_st[k] = 0; m_pos[k] = 0; m_age[k] = 0; m_head[k] = 1;
      end else begin
        mw = !en ? 0 : (mode ? 2 : 1);
        if (mw == 0) begin
          m_age[k] = 0;
        end else if (mw == 1) begin
          m_pos[k] = int'(a) % mn; m_age[k] = 0;
        end else if (m_st[k] != 2) begin
          m_pos[k] = int'(a) % mn; m_age[k] = 0; m_head[k] = dir ? 1 : -1;
        end else begin
          m_age[k]++;
          if (m_age[k] == DV[k]) begin
            m_age[k]  = 0;
            m_step[k] = 1'b1;
            if (BN[k] != 0) begin
              if (m_pos[k] + m_head[k] < 0 || m_pos[k] + m_head[k] >= mn) m_head[k] = -m_head[k];
              m_pos[k] = m_pos[k] + m_head[k];
            end else begin
              m_pos[k] = (m_pos[k] + (dir ? 1 : -1) + mn) % mn;
            end
          end
        end
        m_st[k] = mw;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; mode = 1'b1; dir = 1'b1; a = 2'd2;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++;
      if (led_o[0] !== 4'b0000 || idx_o[0] !== 2'd0 || step_o[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: led=%b idx=%0d step=%b want led=0000 idx=0 step=0",
                 led_o[0], idx_o[0], step_o[0]);
      end
    end
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (led_o[0] !== 4'b0100 || idx_o[0] !== 2'd2 || step_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: led=%b idx=%0d step=%b want led=0100 idx=2 step=0",
               led_o[0], idx_o[0], step_o[0]);
    end
  endtask

  task automatic test_decode;
    logic [3:0] one4;
    logic [3:0] exp_led;
    one4 = 4'b0001;
    en = 1'b1; mode = 1'b0;
    for (int v = 0; v < 4; v++) begin
      a = 2'(v);
      tick();
      exp_led = one4 << v;
      n_chk++;
      if (led_o[0] !== exp_led || idx_o[0] !== 2'(v)) begin
        n_fail++;
        $display("FAIL decode_a%0d: led=%b idx=%0d want led=%b idx=%0d", v, led_o[0], idx_o[0], exp_led, v);
      end
    end
    en = 1'b0;
    tick();
    n_chk++;
    if (led_o[0] !== 4'b0000 || idx_o[0] !== 2'd3) begin
      n_fail++;
      $display("FAIL decode_off: led=%b idx=%0d want led=0000 idx=3", led_o[0], idx_o[0]);
    end
  endtask

  task automatic test_scan_wrap;
    int         exp_idx;
    logic       exp_step;
    logic [3:0] one4;
    one4 = 4'b0001;
    en = 1'b0;
    tick();
    a = 2'd2; dir = 1'b1; mode = 1'b1; en = 1'b1;
    tick();
    n_chk++;
    if (idx_o[0] !== 2'd2 || step_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_entry: idx=%0d step=%b want idx=2 step=0", idx_o[0], step_o[0]);
    end
    for (int s = 1; s <= 4; s++) begin
      for (int c = 1; c <= 4; c++) begin
        tick();
        exp_idx  = (c == 4) ? (2 + s) % 4 : (2 + s - 1) % 4;
        exp_step = (c == 4);
        n_chk++;
        if (idx_o[0] !== 2'(exp_idx) || step_o[0] !== exp_step || led_o[0] !== (one4 << exp_idx)) begin
          n_fail++;
          $display("FAIL wrap_s%0d_c%0d: idx=%0d step=%b led=%b want idx=%0d step=%b",
                   s, c, idx_o[0], step_o[0], led_o[0], exp_idx, exp_step);
        end
      end
    end
  endtask

  task automatic test_scan_down;
    int exp_idx;
    en = 1'b0;
    tick();
    a = 2'd1; dir = 1'b0; mode = 1'b1; en = 1'b1;
    tick();
    n_chk++;
    if (idx_o[1] !== 2'd1 || step_o[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL down_entry: idx=%0d step=%b want idx=1 step=0", idx_o[1], step_o[1]);
    end
    for (int s = 1; s <= 4; s++) begin
      tick();
      exp_idx = (1 - s + 4) % 4;
      n_chk++;
      if (idx_o[1] !== 2'(exp_idx) || step_o[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL down_s%0d: idx=%0d step=%b want idx=%0d step=1", s, idx_o[1], step_o[1], exp_idx);
      end
    end
  endtask

  task automatic test_bounce;
    int bl [7] = '{1, 2, 3, 2, 1, 0, 1};
    en = 1'b0;
    tick();
    a = 2'd0; dir = 1'b1; mode = 1'b1; en = 1'b1;
    tick();
    n_chk++;
    if (idx_o[2] !== 2'd0 || idx_o[3] !== 2'd0) begin
      n_fail++;
      $display("FAIL bounce_entry: idx=%0d idx_w1=%0d want 0 0", idx_o[2], idx_o[3]);
    end
    for (int s = 0; s < 7; s++) begin
      dir = ~dir;
      tick();
      n_chk++;
      if (idx_o[2] !== 2'(bl[s]) || idx_o[3] !== 2'((s + 1) % 2)) begin
        n_fail++;
        $display("FAIL bounce_s%0d: idx=%0d idx_w1=%0d want %0d %0d",
                 s, idx_o[2], idx_o[3], bl[s], (s + 1) % 2);
      end
    end
  endtask

  task automatic test_mid_op;
    en = 1'b0;
    tick();
    a = 2'd3; dir = 1'b1; mode = 1'b1; en = 1'b1;
    tick();
    tick();
    tick();
    en = 1'b0;
    tick();
    n_chk++;
    if (led_o[0] !== 4'b0000 || idx_o[0] !== 2'd3 || step_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_disable: led=%b idx=%0d step=%b want led=0000 idx=3 step=0",
               led_o[0], idx_o[0], step_o[0]);
    end
    a = 2'd1; en = 1'b1;
    tick();
    n_chk++;
    if (led_o[0] !== 4'b0010 || idx_o[0] !== 2'd1 || step_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_restart: led=%b idx=%0d step=%b want led=0010 idx=1 step=0",
               led_o[0], idx_o[0], step_o[0]);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_chk++;
      if (idx_o[0] !== ((c == 4) ? 2'd2 : 2'd1) || step_o[0] !== (c == 4)) begin
        n_fail++;
        $display("FAIL mid_first_step_c%0d: idx=%0d step=%b want idx=%0d step=%b",
                 c, idx_o[0], step_o[0], (c == 4) ? 2 : 1, (c == 4));
      end
    end
    tick();
    rst_n = 1'b0;
    tick();
    n_chk++;
    if (led_o[0] !== 4'b0000 || idx_o[0] !== 2'd0 || step_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: led=%b idx=%0d step=%b want led=0000 idx=0 step=0",
               led_o[0], idx_o[0], step_o[0]);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random;
    logic [3:0] exp_led;
    int         hold;
    for (int seg = 0; seg < 70; seg++) begin
      rst_n = ($urandom_range(0, 24) != 0);
      en    = ($urandom_range(0, 6) != 0);
      mode  = ($urandom_range(0, 2) != 0);
      a     = 2'($urandom_range(0, 3));
      hold  = $urandom_range(1, 12);
      for (int c = 0; c < hold; c++) begin
        dir = 1'($urandom_range(0, 1));
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
          exp_led = (m_st[k] == 0) ? 4'b0000 : 4'(1 << m_pos[k]);
          n_chk++;
          if (led_o[k] !== exp_led || idx_o[k] !== 2'(m_pos[k]) || step_o[k] !== m_step[k]) begin
            n_fail++;
            $display("FAIL random_cfg%0d_seg%0d: led=%b idx=%0d step=%b want led=%b idx=%0d step=%b",
                     k, seg, led_o[k], idx_o[k], step_o[k], exp_led, m_pos[k], m_step[k]);
          end
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b1; a = 2'd0;
    test_reset();
    test_decode();
    test_scan_wrap();
    test_scan_down();
    test_bounce();
    test_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
